// File: rtl/irq_controller_if.sv
// CPU-side interrupt handshake bundle.
//   int_en     : global interrupt enable from the core status register
//   int_ack    : one-cycle pulse, core has taken the interrupt
//   eret       : one-cycle pulse, core executed ERET
//   int_req    : interrupt request to the core
//   int_vector : handler address, valid while int_req=1
//   int_id     : line number being requested
// master = interrupt controller, slave = CPU core.
interface irq_controller_if;
   logic        int_en;
   logic        int_ack;
   logic        eret;
   logic        int_req;
   logic [31:0] int_vector;
   logic [2:0]  int_id;

   modport master (
      input  int_en, int_ack, eret,
      output int_req, int_vector, int_id
   );

   modport slave (
      output int_en, int_ack, eret,
      input  int_req, int_vector, int_id
   );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: synchronises and edge-detects the raw request
// lines, latches pending requests, applies masks and fixed priority
// (line 0 highest), and hands one request plus handler vector to the core.
// Nested service levels are tracked as a bitmap until ERET.
// Ports:
//   Clock, Reset_n : clock, synchronous active-low reset
//   ir             : raw request lines (pulses, at least one edge wide)
//   mask           : 1 = line blocked from requesting (still latched)
//   cpu            : handshake bundle (irq_controller_if.master)
//   pending        : latched, not-yet-acknowledged requests
//   in_service     : lines currently being serviced
//
// state | meaning
// IDLE  | no request outstanding; looks for an eligible line each edge
// REQ   | int_req high, int_id/int_vector frozen until ack or withdraw
module irq_controller #(
   parameter int unsigned N_IRQ      = 3,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0040,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic [N_IRQ-1:0]  ir,
   input  logic [N_IRQ-1:0]  mask,
   irq_controller_if.master  cpu,
   output logic [N_IRQ-1:0]  pending,
   output logic [N_IRQ-1:0]  in_service
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t           state, state_nxt;
   logic [N_IRQ-1:0] sync1, sync2, prev, rise;
   logic [N_IRQ-1:0] pending_nxt, in_service_nxt;
   logic [N_IRQ-1:0] is_lsb, allowed, eligible, id_oh;
   logic             win_valid;
   logic [2:0]       win_id;
   logic             req_nxt;
   logic [2:0]       id_nxt;
   logic [31:0]      vec_nxt;

   // is_lsb isolates the highest-priority line in service; everything
   // below it (lower index) may preempt. Empty stack wraps to all ones.
   always_comb begin
      is_lsb   = in_service & (~in_service + N_IRQ'(1));
      allowed  = is_lsb - N_IRQ'(1);
      eligible = pending & ~mask & allowed;
      id_oh    = N_IRQ'(1) << cpu.int_id;
   end

   // Descending scan so the lowest eligible index is the last one kept.
   always_comb begin
      win_valid = 1'b0;
      win_id    = 3'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_valid = 1'b1;
            win_id    = 3'(i);
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      req_nxt        = cpu.int_req;
      id_nxt         = cpu.int_id;
      vec_nxt        = cpu.int_vector;
      pending_nxt    = pending;
      in_service_nxt = in_service;

      // ERET pops the pre-ack stack top; an ack in the same cycle then pushes.
      if (cpu.eret) in_service_nxt = in_service & ~is_lsb;

      case (state)
         IDLE: begin
            if (cpu.int_en && win_valid) begin
               state_nxt = REQ;
               req_nxt   = 1'b1;
               id_nxt    = win_id;
               vec_nxt   = VEC_BASE + 32'(win_id) * VEC_STRIDE;
            end
         end
         REQ: begin
            if (cpu.int_ack) begin
               pending_nxt    = pending & ~id_oh;
               in_service_nxt = in_service_nxt | id_oh;
               req_nxt        = 1'b0;
               state_nxt      = IDLE;
            end else if (!cpu.int_en) begin
               req_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A fresh edge wins over an ack clear in the same cycle.
      pending_nxt = pending_nxt | rise;
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         sync1          <= '0;
         sync2          <= '0;
         prev           <= '0;
         rise           <= '0;
         state          <= IDLE;
         pending        <= '0;
         in_service     <= '0;
         cpu.int_req    <= 1'b0;
         cpu.int_id     <= '0;
         cpu.int_vector <= '0;
      end else begin
         sync1          <= ir;
         sync2          <= sync1;
         prev           <= sync2;
         rise           <= sync2 & ~prev;
         state          <= state_nxt;
         pending        <= pending_nxt;
         in_service     <= in_service_nxt;
         cpu.int_req    <= req_nxt;
         cpu.int_id     <= id_nxt;
         cpu.int_vector <= vec_nxt;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ir, mask;
   logic [2:0] pending, in_service;

   irq_controller_if cpu();

   irq_controller #(.N_IRQ(3)) dut (
      .Clock      (clk),
      .Reset_n    (rst_n),
      .ir         (ir),
      .mask       (mask),
      .cpu        (cpu.master),
      .pending    (pending),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ir;
      logic [2:0]  mask;
      logic        req;
      logic [2:0]  id;
      logic [31:0] vec;
      logic [2:0]  is_after;
      logic [2:0]  pend_after;
   } vec_t;

   typedef struct {
      logic [2:0]  id;
      logic [31:0] vec;
   } exp_t;

   vec_t tbl[8];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic pulse(input logic [2:0] pat);
      @(negedge clk);
      ir = pat;
      @(negedge clk);
      ir = '0;
   endtask

   task automatic push(input logic [2:0] id, input logic [31:0] vec);
      exp_t e;
      e.id  = id;
      e.vec = vec;
      sb.push_back(e);
   endtask

   // Bounded wait for int_req, then compare against the scoreboard head.
   task automatic expect_req(input string name);
      int   n = 0;
      exp_t e;
      while (cpu.int_req !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      if (cpu.int_req !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: got int_req=%0b expected 1", name, cpu.int_req);
         if (sb.size() > 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_unexpected: got request id=%0d expected none", name, cpu.int_id);
      end else begin
         e = sb.pop_front();
         check({name, "_id"}, 32'(cpu.int_id), 32'(e.id));
         check({name, "_vec"}, cpu.int_vector, e.vec);
      end
   endtask

   task automatic ack();
      cpu.int_ack = 1'b1;
      tick();
      cpu.int_ack = 1'b0;
   endtask

   task automatic do_eret();
      cpu.eret = 1'b1;
      tick();
      cpu.eret = 1'b0;
   endtask

   // Watch int_req for n cycles; one comparison on whether it ever rose.
   task automatic expect_quiet(input string name, input int n);
      logic seen = 1'b0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (cpu.int_req !== 1'b0) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{3'b001, 3'b000, 1'b1, 3'd0, 32'h40, 3'b001, 3'b000};
      tbl[1] = '{3'b010, 3'b000, 1'b1, 3'd1, 32'h50, 3'b010, 3'b000};
      tbl[2] = '{3'b100, 3'b000, 1'b1, 3'd2, 32'h60, 3'b100, 3'b000};
      tbl[3] = '{3'b011, 3'b000, 1'b1, 3'd0, 32'h40, 3'b001, 3'b010};
      tbl[4] = '{3'b111, 3'b001, 1'b1, 3'd1, 32'h50, 3'b010, 3'b101};
      tbl[5] = '{3'b001, 3'b001, 1'b0, 3'd0, 32'h00, 3'b000, 3'b001};
      tbl[6] = '{3'b110, 3'b110, 1'b0, 3'd0, 32'h00, 3'b000, 3'b110};
      tbl[7] = '{3'b101, 3'b100, 1'b1, 3'd0, 32'h40, 3'b001, 3'b100};

      rst_n       = 1'b0;
      ir          = '0;
      mask        = '0;
      cpu.int_en  = 1'b1;
      cpu.int_ack = 1'b0;
      cpu.eret    = 1'b0;
      tick();
      tick();
      check("rst_req", 32'(cpu.int_req), 32'd0);
      check("rst_vec", cpu.int_vector, 32'd0);
      check("rst_pend", 32'(pending), 32'd0);
      check("rst_is", 32'(in_service), 32'd0);
      rst_n = 1'b1;

      // Table-driven single-shot vectors with exact latency checks.
      for (int v = 0; v < 8; v++) begin
         do_reset();
         mask = tbl[v].mask;
         if (tbl[v].req) push(tbl[v].id, tbl[v].vec);
         pulse(tbl[v].ir);          // first sampling edge has passed
         tick();
         tick();
         check($sformatf("v%0d_pend_early", v), 32'(pending), 32'd0);
         tick();
         check($sformatf("v%0d_pend", v), 32'(pending), 32'(tbl[v].ir));
         if (tbl[v].req) begin
            tick();
            check($sformatf("v%0d_req_latency", v), 32'(cpu.int_req), 32'd1);
            expect_req($sformatf("v%0d", v));
            ack();
            check($sformatf("v%0d_req_clr", v), 32'(cpu.int_req), 32'd0);
         end else begin
            expect_quiet($sformatf("v%0d_no_req", v), 6);
         end
         check($sformatf("v%0d_is", v), 32'(in_service), 32'(tbl[v].is_after));
         check($sformatf("v%0d_pend_after", v), 32'(pending), 32'(tbl[v].pend_after));
      end
      mask = '0;

      // Nesting: line 2 in service, line 0 preempts.
      do_reset();
      push(3'd2, 32'h60);
      pulse(3'b100);
      expect_req("nest_outer");
      ack();
      check("nest_is1", 32'(in_service), 32'b100);
      push(3'd0, 32'h40);
      pulse(3'b001);
      expect_req("nest_inner");
      ack();
      check("nest_is2", 32'(in_service), 32'b101);
      do_eret();
      check("nest_eret1", 32'(in_service), 32'b100);
      do_eret();
      check("nest_eret2", 32'(in_service), 32'b000);

      // Simultaneous lines 1 and 2: 2 waits until 1 is retired.
      do_reset();
      push(3'd1, 32'h50);
      pulse(3'b110);
      expect_req("pair_first");
      ack();
      check("pair_is", 32'(in_service), 32'b010);
      expect_quiet("pair_blocked", 8);
      check("pair_pend", 32'(pending), 32'b100);
      push(3'd2, 32'h60);
      do_eret();
      expect_req("pair_second");
      ack();
      do_eret();

      // Mask holds a latched request until released.
      do_reset();
      mask = 3'b001;
      pulse(3'b001);
      expect_quiet("mask_quiet", 6);
      check("mask_pend", 32'(pending), 32'b001);
      mask = 3'b000;
      tick();
      check("unmask_req", 32'(cpu.int_req), 32'd1);
      push(3'd0, 32'h40);
      expect_req("unmask");
      ack();

      // Withdraw on int_en drop, re-raise when restored.
      do_reset();
      push(3'd1, 32'h50);
      pulse(3'b010);
      expect_req("wd_first");
      cpu.int_en = 1'b0;
      tick();
      cpu.int_en = 1'b1;
      check("wd_req_low", 32'(cpu.int_req), 32'd0);
      check("wd_pend", 32'(pending), 32'b010);
      tick();
      check("wd_reraise", 32'(cpu.int_req), 32'd1);
      push(3'd1, 32'h50);
      expect_req("wd_again");
      ack();

      // Reset mid-request with ir0 held high: exactly one request after.
      do_reset();
      ir = 3'b001;
      push(3'd0, 32'h40);
      expect_req("hold_first");
      rst_n = 1'b0;
      tick();
      tick();
      check("hold_rst_req", 32'(cpu.int_req), 32'd0);
      check("hold_rst_id", 32'(cpu.int_id), 32'd0);
      check("hold_rst_vec", cpu.int_vector, 32'd0);
      check("hold_rst_pend", 32'(pending), 32'd0);
      check("hold_rst_is", 32'(in_service), 32'd0);
      rst_n = 1'b1;
      push(3'd0, 32'h40);
      expect_req("hold_after");
      ack();
      check("hold_is", 32'(in_service), 32'b001);
      expect_quiet("hold_once", 8);
      check("hold_pend", 32'(pending), 32'd0);
      ir = '0;

      // ERET and ack in the same cycle: pop old top, then push new line.
      do_reset();
      push(3'd2, 32'h60);
      pulse(3'b100);
      expect_req("eack_outer");
      ack();
      push(3'd0, 32'h40);
      pulse(3'b001);
      expect_req("eack_inner");
      cpu.int_ack = 1'b1;
      cpu.eret    = 1'b1;
      tick();
      cpu.int_ack = 1'b0;
      cpu.eret    = 1'b0;
      check("eack_is", 32'(in_service), 32'b001);

      // Ack while idle is ignored; ERET on an empty stack is harmless.
      ack();
      check("idle_ack_is", 32'(in_service), 32'b001);
      check("idle_ack_req", 32'(cpu.int_req), 32'd0);
      do_eret();
      check("eret_is", 32'(in_service), 32'b000);
      do_eret();
      check("eret_empty_is", 32'(in_service), 32'b000);

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Receiving end of the CPU external interrupt lines ir0..ir2, which the bench and top level drive as short request pulses.
- Synchronises and edge-detects each line, latches pending requests, and applies per-line masks and fixed priority (line 0 highest).
- Presents one request plus a handler vector to the CPU core, with a request/acknowledge handshake.
- Tracks nested in-service levels until the core signals ERET.

Parameters:
- N_IRQ, 3, number of interrupt lines (1..8).
- VEC_BASE, 32'h0000_0040, handler address for line 0.
- VEC_STRIDE, 32'h0000_0010, address spacing between line handlers.

Ports:
- Clock  input  1  system clock; all logic updates on the rising edge.
- Reset_n  input  1  reset; synchronous, active-low.
- ir  input  N_IRQ  raw interrupt request lines; must be high for at least one rising Clock edge.
- mask  input  N_IRQ  1 = line blocked from requesting; its pending bit is still latched.
- int_en  input  1  global interrupt enable from the core status register.
- int_ack  input  1  one-cycle pulse: core has taken the interrupt at an instruction boundary.
- eret  input  1  one-cycle pulse: core executed ERET.
- int_req  output  1  interrupt request to the core.
- int_vector  output  32  handler address; valid while int_req=1.
- int_id  output  3  line number being requested.
- pending  output  N_IRQ  latched, not-yet-acknowledged requests.
- in_service  output  N_IRQ  lines currently being serviced (nesting stack as bitmap).

Behaviour:
- Reset: when Reset_n=0 at an edge, clear everything: sync regs, edge regs, pending, in_service, int_req, int_vector, int_id, and state=IDLE. Reset wins over all other inputs at that edge.
- Input path: 2-FF synchroniser per line, then a rising-edge detect (sync2 & ~prev).
  - An edge sets pending[i] 3 edges after the first edge that samples ir[i]=1.
  - A level held high gives one edge only.
  - A line held high through reset yields one edge after reset release.
- Eligible line: pending & ~mask, with priority strictly higher (lower index) than the highest-priority in_service bit. If in_service is empty, all pending & ~mask lines are eligible. Winner = lowest eligible index.
- FSM, 2 states:
  - IDLE: if int_en=1 and an eligible line exists, go to REQ next edge. On that edge latch int_id=winner, int_vector=VEC_BASE+winner*VEC_STRIDE (32-bit wrap), and set int_req=1.
  - REQ: int_id and int_vector are frozen. A new higher-priority arrival does not retarget the request; it is served after the ack.
    - int_ack=1: clear pending[int_id], set in_service[int_id], int_req=0, go to IDLE.
    - int_en=0 (without ack): withdraw; int_req=0, go to IDLE, pending unchanged. Ack has priority if both occur.
    - mask[int_id] rising while in REQ does not withdraw.
- Minimum turnaround: after an ack, the next request can be raised no earlier than 1 cycle later (IDLE evaluates on the next edge).
- int_ack in IDLE: ignored.
- eret: clear the highest-priority set in_service bit; ignored if in_service=0.
- eret with ack in the same cycle: eret clears a bit of the pre-ack in_service, then the ack's bit is set.
- Edge and clear in the same cycle: if an edge for line i arrives in the same cycle its pending bit is cleared by ack, pending[i] stays 1 (set wins; new request queued).
- Outputs are all registered; int_vector and int_id hold their last values in IDLE.

Test Plan:
- Pulse ir0 for one Clock edge, mask=0, int_en=1 -> pending=3'b001 three edges later, int_req=1 one edge after that, int_id=0, int_vector=32'h40. Ack -> in_service=3'b001, int_req=0. eret -> in_service=0.
- ir1 and ir2 pulse together -> first request int_id=1, vector 32'h50. After ack, no further request (ir2 is lower priority than in-service line 1). After eret, request int_id=2, vector 32'h60.
- ir2 in service, then pulse ir0 -> nested request int_id=0. After ack, in_service=3'b101. First eret -> 3'b100; second eret -> 3'b000.
- mask=3'b001, pulse ir0 -> pending=3'b001, no int_req. Clear mask -> int_req next edge, int_id=0.
- int_req=1 for line 1, drop int_en for one cycle -> int_req=0, pending[1] still 1. Restore int_en -> request re-raised.
- Hold ir0 high, assert Reset_n=0 mid-REQ for 2 cycles -> all outputs 0. After release, exactly one new pending/request for line 0.
